// File: rtl/mem_pkg.sv
// Shared opcode, FSM-state and access-classification definitions for the
// memory-access stage (mem_lsu and mem_lane_align).
package mem_pkg;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8,
    MEMOP_LL   = 4'd9,
    MEMOP_SC   = 4'd10
  } memop_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_NONE = 2'd3;

  function automatic logic is_load(input logic [3:0] op);
    logic r;
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW, MEMOP_LL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    logic r;
    case (op)
      MEMOP_SB, MEMOP_SH, MEMOP_SW, MEMOP_SC: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_signed_load(input logic [3:0] op);
    logic r;
    case (op)
      MEMOP_LB, MEMOP_LH: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] access_size(input logic [3:0] op);
    logic [1:0] r;
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: r = SZ_BYTE;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: r = SZ_HALF;
      MEMOP_LW, MEMOP_SW, MEMOP_LL, MEMOP_SC: r = SZ_WORD;
      default: r = SZ_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables, replicated store data and
// sign/zero-extended load data for a given opcode, address offset and endianness.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 1
) (
  input  logic [3:0]                      op,
  input  logic [$clog2(DATA_W/8)-1:0]     offset,
  input  logic [DATA_W-1:0]               store_data,
  input  logic [DATA_W-1:0]               rdata,
  output logic [DATA_W/8-1:0]             sel,
  output logic [DATA_W-1:0]               wdata,
  output logic [DATA_W-1:0]               ldata
);

  localparam int NB = DATA_W / 8;
  localparam int NH = DATA_W / 16;

  int         byte_lane_s;
  int         half_lane_s;
  logic [7:0] byte_s;
  logic [15:0] half_s;
  logic [1:0] size_s;
  logic       sext_s;

  assign size_s      = access_size(op);
  assign sext_s      = is_signed_load(op);
  // With big-endian numbering, offset 0 lands on the most significant lane.
  assign byte_lane_s = (BIG_ENDIAN != 0) ? (NB - 1 - int'(offset)) : int'(offset);
  assign half_lane_s = (BIG_ENDIAN != 0) ? (NH - 1 - int'(offset) / 2) : (int'(offset) / 2);

  // Pick the addressed byte and halfword out of the read word
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    for (int i = 0; i < NB; i++) begin
      byte_s = byte_s | (rdata[i*8 +: 8] & {8{i == byte_lane_s}});
    end
    for (int i = 0; i < NH; i++) begin
      half_s = half_s | (rdata[i*16 +: 16] & {16{i == half_lane_s}});
    end
  end

  // Byte enables, replicated store data and extended load data per access size
  always_comb begin
    sel   = '0;
    wdata = store_data;
    ldata = rdata;
    case (size_s)
      SZ_BYTE: begin
        for (int i = 0; i < NB; i++) begin
          sel[i] = (i == byte_lane_s);
        end
        wdata = {NB{store_data[7:0]}};
        ldata = {{(DATA_W-8){sext_s & byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        for (int i = 0; i < NB; i++) begin
          sel[i] = ((i / 2) == half_lane_s);
        end
        wdata = {NH{store_data[15:0]}};
        ldata = {{(DATA_W-16){sext_s & half_s[15]}}, half_s};
      end
      SZ_WORD: begin
        sel = '1;
      end
      default: begin
        sel = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage with req/ack data-bus FSM (IDLE/REQ/DONE).
// Optional LL/SC link bit and llbit_o port are enabled by defining MEM_LLSC_EN.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic                  whilo_i,
  input  logic [3:0]            memop_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  whilo_o,
  output logic                  misalign_o,
  output logic                  stall_req_o,
`ifdef MEM_LLSC_EN
  output logic                  llbit_o,
`endif
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W/8-1:0]   mem_sel_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  logic [1:0]        state_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [NB-1:0]     mem_sel_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              discard_r;

  logic [OFF_W-1:0]  offset_s;
  logic [NB-1:0]     sel_s;
  logic [DATA_W-1:0] bus_wdata_s;
  logic [DATA_W-1:0] ldata_s;
  logic [DATA_W-1:0] sc_result_s;
  logic              load_s, store_s, sc_s, access_s;
  logic              sc_pass_s, sc_squash_s;
  logic              unaligned_s, mis_acc_s, go_s, kill_wb_s;

  assign offset_s = mem_addr_i[OFF_W-1:0];
  assign sc_s     = (memop_i == MEMOP_SC);
  assign load_s   = is_load(memop_i);

`ifdef MEM_LLSC_EN
  logic llbit_r;
  logic ll_s;

  assign ll_s        = (memop_i == MEMOP_LL);
  assign store_s     = is_store(memop_i);
  assign sc_pass_s   = llbit_r;
  assign sc_squash_s = 1'b0;
  // SC reports success for the whole stalled sequence once it has started.
  assign sc_result_s = {{(DATA_W-1){1'b0}}, (state_r != ST_IDLE) | llbit_r};
  assign llbit_o     = llbit_r;

  // Link bit: set by a completed LL, cleared by any SC or by a flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llbit_r <= 1'b0;
    end else if (flush_i) begin
      llbit_r <= 1'b0;
    end else if ((state_r == ST_DONE) && ll_s && !discard_r) begin
      llbit_r <= 1'b1;
    end else if ((state_r == ST_DONE) && sc_s) begin
      llbit_r <= 1'b0;
    end else begin
      llbit_r <= llbit_r;
    end
  end
`else
  assign store_s     = is_store(memop_i) & ~sc_s;
  assign sc_pass_s   = 1'b0;
  assign sc_squash_s = sc_s;
  assign sc_result_s = wdata_i;
`endif

  assign access_s = load_s | store_s;

  // Alignment rule follows the access size
  always_comb begin
    unaligned_s = 1'b0;
    case (access_size(memop_i))
      SZ_HALF: unaligned_s = offset_s[0];
      SZ_WORD: unaligned_s = |offset_s;
      default: unaligned_s = 1'b0;
    endcase
  end

  assign mis_acc_s = access_s & unaligned_s;
  assign go_s      = (state_r == ST_IDLE) & access_s & ~unaligned_s & ~flush_i
                   & ~(sc_s & ~sc_pass_s);
  assign kill_wb_s = (state_r == ST_DONE) & (discard_r | flush_i);

  mem_lane_align #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .op         (memop_i),
    .offset     (offset_s),
    .store_data (store_data_i),
    .rdata      (rdata_r),
    .sel        (sel_s),
    .wdata      (bus_wdata_s),
    .ldata      (ldata_s)
  );

  // Bus transaction sequencing; bus fields are latched once and held through REQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_sel_r   <= '0;
      mem_wdata_r <= '0;
      rdata_r     <= '0;
      discard_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            state_r     <= ST_REQ;
            mem_req_r   <= 1'b1;
            mem_we_r    <= store_s;
            mem_addr_r  <= {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_sel_r   <= sel_s;
            mem_wdata_r <= bus_wdata_s;
            discard_r   <= 1'b0;
          end
        end
        ST_REQ: begin
          if (flush_i) begin
            discard_r <= 1'b1;
          end
          if (mem_ack_i) begin
            rdata_r   <= mem_rdata_i;
            mem_req_r <= 1'b0;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          discard_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_sel_o   = mem_sel_r;
  assign mem_wdata_o = mem_wdata_r;

  // Pipeline outputs: pass-through with load/SC results and writeback squashing
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    hi_o        = '0;
    lo_o        = '0;
    whilo_o     = 1'b0;
    misalign_o  = 1'b0;
    stall_req_o = 1'b0;
    if (!rst) begin
      wd_o = '0;
    end else begin
      wd_o        = wd_i;
      hi_o        = hi_i;
      lo_o        = lo_i;
      wreg_o      = wreg_i & ~mis_acc_s & ~kill_wb_s & ~sc_squash_s;
      whilo_o     = whilo_i & ~kill_wb_s;
      misalign_o  = mis_acc_s & ~flush_i & (state_r == ST_IDLE);
      stall_req_o = go_s | (state_r == ST_REQ);
      if (load_s) begin
        wdata_o = ldata_s;
      end else if (sc_s) begin
        wdata_o = sc_result_s;
      end else begin
        wdata_o = wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised self-checking bench for mem_lsu against a byte-arithmetic reference model.
module tb_mem_lsu;
  import mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int BE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [RW-1:0] wd_i, wd_o;
  logic          wreg_i, wreg_o, whilo_i, whilo_o;
  logic [DW-1:0] wdata_i, wdata_o, hi_i, hi_o, lo_i, lo_o;
  logic [3:0]    memop_i;
  logic [AW-1:0] mem_addr_i, mem_addr_o;
  logic [DW-1:0] store_data_i, mem_wdata_o, mem_rdata_i;
  logic          flush_i, misalign_o, stall_req_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [3:0]    mem_sel_o;
`ifdef MEM_LLSC_EN
  logic          llbit_o;
`endif

  always #5 clk = ~clk;

  mem_lsu #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .memop_i(memop_i),
    .mem_addr_i(mem_addr_i), .store_data_i(store_data_i), .flush_i(flush_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
    .whilo_o(whilo_o), .misalign_o(misalign_o), .stall_req_o(stall_req_o),
`ifdef MEM_LLSC_EN
    .llbit_o(llbit_o),
`endif
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Observations recorded by run_mem for the calling test to judge
  int          o_stall, o_req;
  logic [31:0] o_addr, o_bwdata, o_res_wdata;
  logic [3:0]  o_sel;
  logic        o_we, o_res_wreg, o_res_whilo, o_unstable, o_timeout, o_mis0;

  // Reference model: access width in bytes, sign behaviour and lane arithmetic
  function automatic int nbytes(input logic [3:0] op);
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: return 1;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 2;
      MEMOP_LW, MEMOP_SW, MEMOP_LL, MEMOP_SC: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int lane_shift(input int nb, input logic [31:0] addr);
    int off;
    off = int'(addr[1:0]);
    return (BE != 0) ? (4 - nb - off) : off;
  endfunction

  function automatic logic [3:0] m_sel(input int nb, input logic [31:0] addr);
    logic [3:0] m;
    if (nb == 4) return 4'hF;
    m = (nb == 1) ? 4'b0001 : 4'b0011;
    return m << lane_shift(nb, addr);
  endfunction

  function automatic logic [31:0] m_store(input int nb, input logic [31:0] d);
    if (nb == 1) return {4{d[7:0]}};
    if (nb == 2) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd);
    int          nb;
    logic [31:0] v;
    nb = nbytes(op);
    if (nb == 4) return rd;
    v = rd >> (8 * lane_shift(nb, addr));
    if (nb == 1) return (op == MEMOP_LB) ? 32'($signed(v[7:0])) : {24'h0, v[7:0]};
    return (op == MEMOP_LH) ? 32'($signed(v[15:0])) : {16'h0, v[15:0]};
  endfunction

  task automatic idle_inputs();
    memop_i = MEMOP_NONE; flush_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  // Present one instruction, ack after `delay` extra REQ cycles, record what the DUT did
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rd, input int delay, input logic fl,
                         input logic wr, input logic wh);
    o_stall = 0; o_req = 0; o_unstable = 1'b0; o_timeout = 1'b1; o_mis0 = 1'b0;
    o_sel = 4'h0; o_addr = 32'h0; o_bwdata = 32'h0; o_we = 1'b0;
    o_res_wdata = 32'h0; o_res_wreg = 1'b0; o_res_whilo = 1'b0;
    memop_i = op; mem_addr_i = addr; store_data_i = sd; wreg_i = wr; whilo_i = wh;
    wd_i = 5'd7; wdata_i = 32'hDEAD_BEEF;
    for (int c = 0; c < 20; c++) begin
      mem_ack_i   = (c == delay + 1);
      mem_rdata_i = (c == delay + 1) ? rd : $urandom;
      flush_i     = fl && (c == 1);
      @(negedge clk);
      if (c == 0) o_mis0 = misalign_o;
      if (mem_req_o) begin
        if (o_req == 0) begin
          o_addr = mem_addr_o; o_sel = mem_sel_o; o_bwdata = mem_wdata_o; o_we = mem_we_o;
        end else if (o_addr !== mem_addr_o || o_sel !== mem_sel_o ||
                     o_bwdata !== mem_wdata_o || o_we !== mem_we_o) begin
          o_unstable = 1'b1;
        end
        o_req++;
      end
      if (stall_req_o) begin
        o_stall++;
      end else begin
        o_res_wdata = wdata_o; o_res_wreg = wreg_o; o_res_whilo = whilo_o; o_timeout = 1'b0;
      end
      @(posedge clk); #1;
      if (!o_timeout) break;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    memop_i = MEMOP_LW; mem_addr_i = 32'h3; wd_i = 5'd9; wreg_i = 1'b1; whilo_i = 1'b1;
    wdata_i = 32'h1111_2222; hi_i = 32'h3333_4444; lo_i = 32'h5555_6666;
    store_data_i = 32'h0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #2;
    total_cnt++; if ({wd_o, wreg_o, whilo_o} !== 7'h0) $display("FAIL reset_ctl got=%h exp=0", {wd_o, wreg_o, whilo_o}); else pass_cnt++;
    total_cnt++; if ({wdata_o, hi_o, lo_o} !== 96'h0) $display("FAIL reset_data got=%h exp=0", {wdata_o, hi_o, lo_o}); else pass_cnt++;
    total_cnt++; if ({misalign_o, stall_req_o, mem_req_o} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {misalign_o, stall_req_o, mem_req_o}); else pass_cnt++;
    @(negedge clk); idle_inputs(); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      wd_i = (k == 0) ? 5'd3 : 5'($urandom); wreg_i = (k == 0) ? 1'b1 : 1'($urandom);
      wdata_i = (k == 0) ? 32'h1234 : $urandom; hi_i = $urandom; lo_i = $urandom;
      whilo_i = 1'($urandom); mem_addr_i = $urandom;
      #1;
      total_cnt++; if ({wd_o, wreg_o, wdata_o} !== {wd_i, wreg_i, wdata_i}) $display("FAIL pass_wb got=%h exp=%h", {wd_o, wreg_o, wdata_o}, {wd_i, wreg_i, wdata_i}); else pass_cnt++;
      total_cnt++; if ({hi_o, lo_o, whilo_o} !== {hi_i, lo_i, whilo_i}) $display("FAIL pass_hilo got=%h exp=%h", {hi_o, lo_o, whilo_o}, {hi_i, lo_i, whilo_i}); else pass_cnt++;
      total_cnt++; if ({stall_req_o, mem_req_o, misalign_o} !== 3'b000) $display("FAIL pass_nostall got=%b exp=000", {stall_req_o, mem_req_o, misalign_o}); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lb_example();
    run_mem(MEMOP_LB, 32'h101, 32'h0, 32'h11FF_2233, 0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (o_sel !== 4'b0100) $display("FAIL lb_sel got=%b exp=0100", o_sel); else pass_cnt++;
    total_cnt++; if (o_stall !== 2) $display("FAIL lb_stall got=%0d exp=2", o_stall); else pass_cnt++;
    total_cnt++; if (o_res_wdata !== 32'hFFFF_FFFF) $display("FAIL lb_data got=%h exp=ffffffff", o_res_wdata); else pass_cnt++;
  endtask

  task automatic test_sh_example();
    run_mem(MEMOP_SH, 32'h202, 32'h0000_ABCD, 32'h0, 2, 1'b0, 1'b0, 1'b0);
    total_cnt++; if (o_bwdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata got=%h exp=abcdabcd", o_bwdata); else pass_cnt++;
    total_cnt++; if (o_sel !== 4'b0011) $display("FAIL sh_sel got=%b exp=0011", o_sel); else pass_cnt++;
    total_cnt++; if ({o_req, o_stall} !== {32'd3, 32'd4}) $display("FAIL sh_cycles got=req %0d stall %0d exp=req 3 stall 4", o_req, o_stall); else pass_cnt++;
    total_cnt++; if ({o_we, o_addr} !== {1'b1, 32'h200}) $display("FAIL sh_bus got=%h exp=%h", {o_we, o_addr}, {1'b1, 32'h200}); else pass_cnt++;
  endtask

  task automatic test_misalign();
    logic [3:0] mops [4];
    logic [3:0] op;
    logic [31:0] addr;
    mops = '{MEMOP_LW, MEMOP_SW, MEMOP_LH, MEMOP_SH};
    for (int k = 0; k < 6; k++) begin
      op = (k == 0) ? MEMOP_LW : mops[$urandom_range(0, 3)];
      addr = (k == 0) ? 32'h3 : (($urandom & 32'hFFFF_FFFC) | ((nbytes(op) == 2) ? 32'h1 : 32'($urandom_range(1, 3))));
      run_mem(op, addr, $urandom, $urandom, 0, 1'b0, 1'b1, 1'b1);
      total_cnt++; if ({o_mis0, o_res_wreg, o_res_whilo} !== 3'b101) $display("FAIL mis_flags got=%b exp=101 addr=%h", {o_mis0, o_res_wreg, o_res_whilo}, addr); else pass_cnt++;
      total_cnt++; if ({o_req, o_stall, 31'h0, o_timeout} !== 96'h0) $display("FAIL mis_nobus got=req %0d stall %0d exp=0 0", o_req, o_stall); else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    run_mem(MEMOP_LHU, 32'h10, 32'h0, 32'h8765_4321, 1, 1'b1, 1'b1, 1'b1);
    total_cnt++; if (o_req !== 2) $display("FAIL flush_req got=%0d exp=2", o_req); else pass_cnt++;
    total_cnt++; if ({o_res_wreg, o_res_whilo} !== 2'b00) $display("FAIL flush_wb got=%b exp=00", {o_res_wreg, o_res_whilo}); else pass_cnt++;
    memop_i = MEMOP_LW; mem_addr_i = 32'h20; flush_i = 1'b1; wreg_i = 1'b1;
    @(negedge clk);
    total_cnt++; if (stall_req_o !== 1'b0) $display("FAIL flush_idle_stall got=%b exp=0", stall_req_o); else pass_cnt++;
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    total_cnt++; if ({mem_req_o, wreg_o} !== 2'b01) $display("FAIL flush_idle_after got=%b exp=01", {mem_req_o, wreg_o}); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_req();
    memop_i = MEMOP_LW; mem_addr_i = 32'h40; wreg_i = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (mem_req_o !== 1'b1) $display("FAIL rmid_req got=%b exp=1", mem_req_o); else pass_cnt++;
    #1 rst = 1'b0; #1;
    total_cnt++; if ({mem_req_o, stall_req_o, wreg_o} !== 3'b000) $display("FAIL rmid_clear got=%b exp=000", {mem_req_o, stall_req_o, wreg_o}); else pass_cnt++;
    @(negedge clk); idle_inputs(); rst = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = $urandom;
    @(posedge clk); #1; mem_ack_i = 1'b0;
    @(negedge clk);
    total_cnt++; if ({mem_req_o, stall_req_o, wreg_o} !== 3'b001) $display("FAIL rmid_ack_ignored got=%b exp=001", {mem_req_o, stall_req_o, wreg_o}); else pass_cnt++;
    @(posedge clk); #1;
    run_mem(MEMOP_LW, 32'h44, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if ({o_stall, o_res_wdata} !== {32'd2, 32'hCAFE_F00D}) $display("FAIL rmid_next got=stall %0d data %h exp=stall 2 data cafef00d", o_stall, o_res_wdata); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0] ops [8];
    logic [3:0] op;
    logic [31:0] addr, sd, rd;
    int nb, d;
    logic ld;
    ops = '{MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW, MEMOP_SB, MEMOP_SH, MEMOP_SW};
    for (int k = 0; k < 24; k++) begin
      op = ops[$urandom_range(0, 7)]; nb = nbytes(op);
      addr = $urandom & ~(32'(nb) - 32'd1);
      sd = $urandom; rd = $urandom; d = $urandom_range(0, 3);
      ld = (op == MEMOP_LB || op == MEMOP_LBU || op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_LW);
      run_mem(op, addr, sd, rd, d, 1'b0, ld, 1'b0);
      total_cnt++; if ({o_timeout, o_unstable} !== 2'b00) $display("FAIL rnd_flow got=%b exp=00 op=%0d", {o_timeout, o_unstable}, op); else pass_cnt++;
      total_cnt++; if ({o_stall, o_req} !== {32'(d + 2), 32'(d + 1)}) $display("FAIL rnd_cycles got=stall %0d req %0d exp=stall %0d req %0d", o_stall, o_req, d + 2, d + 1); else pass_cnt++;
      total_cnt++; if ({o_we, o_addr, o_sel} !== {~ld, addr & 32'hFFFF_FFFC, m_sel(nb, addr)}) $display("FAIL rnd_bus got=%h exp=%h op=%0d", {o_we, o_addr, o_sel}, {~ld, addr & 32'hFFFF_FFFC, m_sel(nb, addr)}, op); else pass_cnt++;
      total_cnt++; if (o_res_wreg !== ld) $display("FAIL rnd_wreg got=%b exp=%b", o_res_wreg, ld); else pass_cnt++;
      if (ld) begin
        total_cnt++; if (o_res_wdata !== m_load(op, addr, rd)) $display("FAIL rnd_load got=%h exp=%h op=%0d addr=%h", o_res_wdata, m_load(op, addr, rd), op, addr); else pass_cnt++;
      end else begin
        total_cnt++; if (o_bwdata !== m_store(nb, sd)) $display("FAIL rnd_store got=%h exp=%h op=%0d", o_bwdata, m_store(nb, sd), op); else pass_cnt++;
      end
    end
  endtask

  task automatic test_sc();
`ifdef MEM_LLSC_EN
    run_mem(MEMOP_LL, 32'h80, 32'h0, 32'h1357_9BDF, 0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if ({o_res_wdata, llbit_o} !== {32'h1357_9BDF, 1'b1}) $display("FAIL ll_link got=%h exp=%h", {o_res_wdata, llbit_o}, {32'h1357_9BDF, 1'b1}); else pass_cnt++;
    run_mem(MEMOP_SC, 32'h80, 32'h2468_ACE0, 32'h0, 1, 1'b0, 1'b1, 1'b0);
    total_cnt++; if ({o_req, o_we, o_sel, o_bwdata} !== {32'd2, 1'b1, 4'hF, 32'h2468_ACE0}) $display("FAIL sc_store got=req %0d we %b sel %h data %h", o_req, o_we, o_sel, o_bwdata); else pass_cnt++;
    total_cnt++; if ({o_res_wdata, llbit_o} !== {32'd1, 1'b0}) $display("FAIL sc_ok got=%h exp=%h", {o_res_wdata, llbit_o}, {32'd1, 1'b0}); else pass_cnt++;
    run_mem(MEMOP_SC, 32'h80, 32'h2468_ACE0, 32'h0, 0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if ({o_req, o_stall, o_res_wdata} !== {32'd0, 32'd0, 32'd0}) $display("FAIL sc_fail got=req %0d stall %0d data %h exp=0 0 0", o_req, o_stall, o_res_wdata); else pass_cnt++;
`else
    run_mem(MEMOP_SC, 32'h80, 32'h2468_ACE0, 32'h0, 0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if ({o_req, o_stall} !== {32'd0, 32'd0}) $display("FAIL sc_none got=req %0d stall %0d exp=0 0", o_req, o_stall); else pass_cnt++;
    total_cnt++; if ({o_res_wreg, o_res_wdata} !== {1'b0, 32'hDEAD_BEEF}) $display("FAIL sc_wb got=%h exp=%h", {o_res_wreg, o_res_wdata}, {1'b0, 32'hDEAD_BEEF}); else pass_cnt++;
    run_mem(MEMOP_LL, 32'h84, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if ({o_stall, o_res_wdata} !== {32'd2, 32'h0BAD_F00D}) $display("FAIL ll_as_lw got=stall %0d data %h exp=2 0badf00d", o_stall, o_res_wdata); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lb_example();
    test_sh_example();
    test_misalign();
    test_flush();
    test_reset_mid_req();
    test_random();
    test_sc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised successor to the pass-through memory-access stage. It sits between the EX/MEM and MEM/WB pipeline registers.
- Non-memory instructions pass through combinationally, including the writeback and HI/LO fields.
- Loads and stores run a req/ack transaction on the data bus. The block stalls the pipeline until the transaction completes.
- It handles byte-lane selection, store-data replication, load extension and misalignment detection.

Parameters:
- DATA_W, 32, data/register width; multiple of 16.
- ADDR_W, 32, data-bus address width.
- REG_ADDR_W, 5, register-file address width.
- BIG_ENDIAN, 1, 1 = address offset 0 maps to the MSB lane; 0 = offset 0 maps to the LSB lane.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- wd_i  in  REG_ADDR_W  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  DATA_W  ALU result
- hi_i  in  DATA_W  HI value
- lo_i  in  DATA_W  LO value
- whilo_i  in  1  HI/LO write enable
- memop_i  in  4  memory opcode (package enum)
- mem_addr_i  in  ADDR_W  effective address
- store_data_i  in  DATA_W  rt value for stores
- flush_i  in  1  pipeline flush
- wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o  out  as inputs  to MEM/WB
- misalign_o  out  1  address-error flag, valid in the current cycle
- stall_req_o  out  1  stall request to the pipeline controller
- mem_req_o  out  1  bus request (registered)
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  word-aligned address
- mem_sel_o  out  DATA_W/8  byte enables
- mem_wdata_o  out  DATA_W  write data
- mem_ack_i  in  1  completion, one-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid with ack

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; mem_req_o=0.
  - Captured read data is cleared to 0.
  - All pipeline outputs are 0; misalign_o=0 and stall_req_o=0.
- Opcodes: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC.
- Non-memory ops (NONE): outputs equal inputs combinationally; no stall; zero latency.
- Misalignment:
  - A halfword access with addr[0]!=0 is misaligned.
  - A word access with addr[1:0]!=0 is misaligned.
  - On misalignment: misalign_o=1, no bus request, wreg_o=0, whilo_o passes through, no stall.
- FSM states: IDLE, REQ, DONE.
  - IDLE: an aligned memory op and !flush_i asserts stall_req_o combinationally. The next state is REQ.
  - REQ: mem_req_o=1, and mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o are held stable. stall_req_o=1. When mem_ack_i=1, mem_rdata_i is captured, mem_req_o drops on the next edge, and the next state is DONE.
  - DONE: stall_req_o=0. Pipeline outputs present the final result. The next state is IDLE.
- Upstream must hold all inputs stable while stall_req_o=1 and during DONE.
- Load latency: a load presented in cycle N with ack in cycle N+1 has its result visible in cycle N+2.
  - stall_req_o is high in cycles N and N+1.
  - Each extra wait cycle adds one cycle.
- Load data:
  - The selected lane is sign-extended for LB/LH and zero-extended for LBU/LHU.
  - LW/LL use the full word.
  - wdata_o carries the result.
- Stores:
  - The byte is replicated on all lanes; the halfword is replicated on both halves.
  - mem_sel_o is one-hot (byte), two-hot (half), or all-ones (word).
  - wreg_o passes wreg_i through, which is normally 0.
- Lane mapping uses BIG_ENDIAN. With BIG_ENDIAN=1, offset 0 maps to sel bit DATA_W/8-1.
- mem_addr_o is mem_addr_i with its low log2(DATA_W/8) bits zeroed.
- Flush:
  - flush_i in IDLE starts nothing.
  - flush_i in REQ does not abort the bus transaction. A discard flag is set, and in DONE wreg_o=0 and whilo_o=0.
  - flush_i in DONE forces wreg_o=0 and whilo_o=0.
- An ack while in IDLE or DONE is ignored.

Optional Feature:
- Macro: MEM_LLSC_EN.
- With MEM_LLSC_EN defined:
  - A 1-bit llbit register is added, reset to 0.
  - LL sets llbit in DONE.
  - SC with llbit=1 performs a word store and writes 1 to wdata_o in DONE.
  - SC with llbit=0 issues no request, writes 0 to wdata_o, and does not stall.
  - SC always clears llbit. flush_i also clears llbit.
  - Output llbit_o (1 bit) is added.
- Without MEM_LLSC_EN: LL behaves as LW, SC behaves as NONE with wreg_o forced to 0, and there is no llbit_o port.

Decomposition:
- Shared package mem_pkg holds:
  - memop_e enum (4-bit codes).
  - State enum for IDLE/REQ/DONE.
  - Helper functions is_load, is_store, access_size.
- One natural sub-module, mem_lane_align:
  - Combinational; computes mem_sel_o, mem_wdata_o and the extended load data from opcode, offset and BIG_ENDIAN.
  - The parent holds the FSM and the flush/llbit logic.

Test Plan:
- memop_i=NONE, wdata_i=0x1234, wreg_i=1, wd_i=3 -> identical outputs the same cycle, stall_req_o=0, mem_req_o=0.
- LB at addr 0x101, rdata 0x11FF2233, BIG_ENDIAN=1, ack on first REQ cycle -> sel=0100, stall two cycles, wdata_o=0xFFFFFFFF in DONE.
- SH at addr 0x202, store_data 0xABCD, 3-cycle ack delay -> mem_wdata_o=0xABCDABCD, sel=0011 (BIG_ENDIAN=1), req held 3 cycles, stall for 4 cycles.
- LW at addr 0x3 -> misalign_o=1, wreg_o=0, no req, no stall.
- LHU in REQ with flush_i pulsed -> transaction completes on ack, wreg_o=0 in DONE.
- Reset mid-REQ -> mem_req_o=0 immediately, state IDLE; a later ack is ignored.
- MEM_LLSC_EN: LL then SC -> wdata_o=1 and a store is issued; a second SC -> wdata_o=0 and no request.
